// File: rtl/sr_latch_arbiter_if.sv
// Request/latch-pin bundle for sr_latch_arbiter. The err_cnt signal exists only
// when SR_ERR_CNT_EN is defined.
interface sr_latch_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req_s;
    logic [NREQ-1:0] req_r;
    logic [NREQ-1:0] done;
    logic            err;
    logic            busy;
    logic            lat_s;
    logic            lat_r;
    logic            lat_en;
    logic            q_mirror;
`ifdef SR_ERR_CNT_EN
    logic [7:0]      err_cnt;

    modport master (
        output req_s, req_r,
        input  done, err, busy, lat_s, lat_r, lat_en, q_mirror, err_cnt
    );

    modport slave (
        input  req_s, req_r,
        output done, err, busy, lat_s, lat_r, lat_en, q_mirror, err_cnt
    );
`else
    modport master (
        output req_s, req_r,
        input  done, err, busy, lat_s, lat_r, lat_en, q_mirror
    );

    modport slave (
        input  req_s, req_r,
        output done, err, busy, lat_s, lat_r, lat_en, q_mirror
    );
`endif
endinterface

// File: rtl/sr_latch_arbiter.sv
// Round-robin arbiter driving one shared SR latch as setup -> enable pulse -> hold.
// Optional saturating error counter enabled by defining SR_ERR_CNT_EN.
module sr_latch_arbiter #(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 2
) (
    input logic               clk,
    input logic               rst_n,
    sr_latch_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win_q, win_sel, win_nx;
    logic            op_set_q, op_set_sel;
    logic            op_ill_q, op_ill_sel;
    logic [CW-1:0]   cnt;
    logic            cnt_last;
    logic            found;
    logic [NREQ-1:0] pend;
    logic            drive;

    logic [NREQ-1:0] done_nx, done_q;
    logic            err_nx, err_q;
    logic            busy_nx, busy_q;
    logic            lat_s_nx, lat_s_q;
    logic            lat_r_nx, lat_r_q;
    logic            lat_en_nx, lat_en_q;
    logic            q_mirror_q;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(NREQ - 1)) return '0;
        return p + PW'(1);
    endfunction

`ifdef SR_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        if (v == 8'hFF) return v;
        return v + 8'd1;
    endfunction
`endif

    assign pend     = bus.req_s | bus.req_r;
    assign cnt_last = (cnt == CW'(HOLD_CYCLES - 1));

    // First pending requester at or after ptr, wrapping around.
    always_comb begin : scan
        int             idx;
        logic [PW-1:0]  cand;
        found  = 1'b0;
        win_nx = ptr;
        idx    = 0;
        cand   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx  = (int'(ptr) + k) % NREQ;
            cand = PW'(idx);
            if (!found && pend[cand]) begin
                found  = 1'b1;
                win_nx = cand;
            end
        end
    end

    always_comb begin : fsm_comb
        state_nx   = state;
        win_sel    = win_q;
        op_set_sel = op_set_q;
        op_ill_sel = op_ill_q;
        case (state)
            S_IDLE: begin
                if (found) begin
                    win_sel    = win_nx;
                    op_set_sel = bus.req_s[win_nx];
                    op_ill_sel = bus.req_s[win_nx] & bus.req_r[win_nx];
                    state_nx   = (bus.req_s[win_nx] & bus.req_r[win_nx]) ? S_DONE : S_SETUP;
                end
            end
            S_SETUP: state_nx = S_PULSE;
            S_PULSE: if (cnt_last) state_nx = S_HOLD;
            S_HOLD:  state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        // Pins are decoded from the next state and registered, so they never glitch.
        drive     = (state_nx == S_SETUP) || (state_nx == S_PULSE) || (state_nx == S_HOLD);
        lat_s_nx  = drive && op_set_sel;
        lat_r_nx  = drive && !op_set_sel;
        lat_en_nx = (state_nx == S_PULSE);
        busy_nx   = (state_nx != S_IDLE);
        done_nx   = '0;
        if (state_nx == S_DONE) done_nx[win_sel] = 1'b1;
        err_nx    = (state_nx == S_DONE) && op_ill_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ptr        <= '0;
            win_q      <= '0;
            op_set_q   <= 1'b0;
            op_ill_q   <= 1'b0;
            cnt        <= '0;
            q_mirror_q <= 1'b0;
            done_q     <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            lat_s_q    <= 1'b0;
            lat_r_q    <= 1'b0;
            lat_en_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            win_q    <= win_sel;
            op_set_q <= op_set_sel;
            op_ill_q <= op_ill_sel;
            cnt      <= (state == S_PULSE) ? cnt + CW'(1) : '0;
            if (state == S_PULSE && cnt_last) q_mirror_q <= op_set_q;
            if (state == S_DONE) ptr <= next_ptr(win_q);
            done_q   <= done_nx;
            err_q    <= err_nx;
            busy_q   <= busy_nx;
            lat_s_q  <= lat_s_nx;
            lat_r_q  <= lat_r_nx;
            lat_en_q <= lat_en_nx;
        end
    end

`ifdef SR_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      err_cnt_q <= 8'h00;
        else if (err_nx) err_cnt_q <= sat_inc(err_cnt_q);
    end

    assign bus.err_cnt = err_cnt_q;
`endif

    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.busy     = busy_q;
    assign bus.lat_s    = lat_s_q;
    assign bus.lat_r    = lat_r_q;
    assign bus.lat_en   = lat_en_q;
    assign bus.q_mirror = q_mirror_q;

endmodule

// File: tb/tb_sr_latch_arbiter.sv
// Bench for sr_latch_arbiter (NREQ=4, HOLD_CYCLES=2): scoreboard of expected
// completions, checked as each done pulse arrives.
module tb_sr_latch_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sr_latch_arbiter_if #(.NREQ(4)) bus ();
    sr_latch_arbiter #(.NREQ(4), .HOLD_CYCLES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [3:0] mask;
        logic       err;
        logic       q;
    } exp_t;

    exp_t sb[$];
    int   mp = 0;
    logic mq = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   both_cnt = 0;

    always @(negedge clk) if (bus.lat_s && bus.lat_r) both_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Predict the next winner from the requests as they will be sampled.
    task automatic model_push(input logic [3:0] ps, input logic [3:0] pr, output int w);
        exp_t x;
        w = -1;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (mp + k) % 4;
            if (w < 0 && (ps[i] | pr[i])) w = i;
        end
        if (w < 0) w = 0;
        x.mask = 4'b0001 << w;
        x.err  = ps[w] & pr[w];
        if (!x.err) mq = ps[w];
        x.q = mq;
        sb.push_back(x);
        mp = (w + 1) % 4;
    endtask

    task automatic wait_done(input int budget, output logic [3:0] d, output logic e,
                             output logic q, output int edges, output int s_cyc,
                             output int r_cyc, output int en_cyc);
        d = '0; e = 1'b0; q = 1'b0;
        edges = 0; s_cyc = 0; r_cyc = 0; en_cyc = 0;
        while (edges < budget) begin
            @(negedge clk);
            edges++;
            if (bus.lat_s)  s_cyc++;
            if (bus.lat_r)  r_cyc++;
            if (bus.lat_en) en_cyc++;
            if (bus.done != 4'b0000) begin
                d = bus.done; e = bus.err; q = bus.q_mirror;
                return;
            end
        end
        edges = -1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; bus.req_s = '0; bus.req_r = '0;
        repeat (2) @(negedge clk);
        n_chk++; if (bus.done !== 4'b0000) $display("FAIL rst_done got %b want 0000", bus.done); else n_pass++;
        n_chk++; if (bus.err !== 1'b0) $display("FAIL rst_err got %b want 0", bus.err); else n_pass++;
        n_chk++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", bus.busy); else n_pass++;
        n_chk++; if ({bus.lat_s, bus.lat_r, bus.lat_en} !== 3'b000)
            $display("FAIL rst_pins got %b want 000", {bus.lat_s, bus.lat_r, bus.lat_en}); else n_pass++;
        n_chk++; if (bus.q_mirror !== 1'b0) $display("FAIL rst_q got %b want 0", bus.q_mirror); else n_pass++;
`ifdef SR_ERR_CNT_EN
        n_chk++; if (bus.err_cnt !== 8'h00) $display("FAIL rst_errcnt got %h want 00", bus.err_cnt); else n_pass++;
`endif
        rst_n = 1'b1; mp = 0; mq = 1'b0;
    endtask

    task automatic test_single_set;
        logic [3:0] d; logic e, q; int ed, sc, rc, ec, w; exp_t x;
        bus.req_s = 4'b0001;
        model_push(bus.req_s, bus.req_r, w);
        wait_done(20, d, e, q, ed, sc, rc, ec);
        bus.req_s &= ~d; bus.req_r &= ~d;
        x = sb.pop_front();
        n_chk++; if (ed !== 5) $display("FAIL t1_latency got %0d want 5", ed); else n_pass++;
        n_chk++; if (sc !== 4) $display("FAIL t1_lat_s_cycles got %0d want 4", sc); else n_pass++;
        n_chk++; if (ec !== 2) $display("FAIL t1_lat_en_cycles got %0d want 2", ec); else n_pass++;
        n_chk++; if (rc !== 0) $display("FAIL t1_lat_r_cycles got %0d want 0", rc); else n_pass++;
        n_chk++; if (d !== x.mask) $display("FAIL t1_done got %b want %b", d, x.mask); else n_pass++;
        n_chk++; if (e !== x.err) $display("FAIL t1_err got %b want %b", e, x.err); else n_pass++;
        n_chk++; if (q !== x.q) $display("FAIL t1_q got %b want %b", q, x.q); else n_pass++;
        n_chk++; if (bus.busy !== 1'b1) $display("FAIL t1_busy_done got %b want 1", bus.busy); else n_pass++;
        @(negedge clk);
        n_chk++; if (bus.busy !== 1'b0) $display("FAIL t1_busy_idle got %b want 0", bus.busy); else n_pass++;
        n_chk++; if (bus.done !== 4'b0000) $display("FAIL t1_done_pulse got %b want 0000", bus.done); else n_pass++;
    endtask

    task automatic test_two_requests;
        logic [3:0] d; logic e, q; int ed, sc, rc, ec, w; exp_t x;
        logic [3:0] ps, pr;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin bus.req_s = 4'b0010; bus.req_r = 4'b0100; end
            else begin @(negedge clk); bus.req_s = 4'b0001; bus.req_r = 4'b1000; end
            ps = bus.req_s; pr = bus.req_r;
            for (int n = 0; n < 2; n++) begin
                model_push(ps, pr, w);
                ps[w] = 1'b0; pr[w] = 1'b0;
            end
            for (int n = 0; n < 2; n++) begin
                wait_done(20, d, e, q, ed, sc, rc, ec);
                bus.req_s &= ~d; bus.req_r &= ~d;
                x = sb.pop_front();
                n_chk++; if (d !== x.mask) $display("FAIL t2_done[%0d.%0d] got %b want %b", pass, n, d, x.mask); else n_pass++;
                n_chk++; if (q !== x.q) $display("FAIL t2_q[%0d.%0d] got %b want %b", pass, n, q, x.q); else n_pass++;
                n_chk++; if (e !== x.err) $display("FAIL t2_err[%0d.%0d] got %b want %b", pass, n, e, x.err); else n_pass++;
                n_chk++; if (ed !== ((n == 0) ? 5 : 6))
                    $display("FAIL t2_latency[%0d.%0d] got %0d want %0d", pass, n, ed, (n == 0) ? 5 : 6); else n_pass++;
            end
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] d, prev; logic e, q; int ed, sc, rc, ec, w; exp_t x;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; mp = 0; mq = 1'b0;
        bus.req_s = 4'b0101; bus.req_r = 4'b1010;
        for (int n = 0; n < 5; n++) model_push(bus.req_s, bus.req_r, w);
        prev = '0;
        for (int n = 0; n < 5; n++) begin
            wait_done(20, d, e, q, ed, sc, rc, ec);
            if (n == 4) begin bus.req_s = '0; bus.req_r = '0; end
            x = sb.pop_front();
            n_chk++; if (d !== x.mask) $display("FAIL t3_order[%0d] got %b want %b", n, d, x.mask); else n_pass++;
            n_chk++; if (q !== x.q) $display("FAIL t3_q[%0d] got %b want %b", n, q, x.q); else n_pass++;
            n_chk++; if (ed !== ((n == 0) ? 5 : 6))
                $display("FAIL t3_latency[%0d] got %0d want %0d", n, ed, (n == 0) ? 5 : 6); else n_pass++;
            if (n > 0) begin
                n_chk++; if (d === prev) $display("FAIL t3_repeat[%0d] got %b want not %b", n, d, prev); else n_pass++;
            end
            prev = d;
        end
    endtask

    task automatic test_illegal;
        logic [3:0] d; logic e, q; int ed, sc, rc, ec, w; exp_t x;
        @(negedge clk);
        bus.req_s = 4'b1000; bus.req_r = 4'b1000;
        model_push(bus.req_s, bus.req_r, w);
        wait_done(20, d, e, q, ed, sc, rc, ec);
        bus.req_s &= ~d; bus.req_r &= ~d;
        x = sb.pop_front();
        n_chk++; if (ed !== 1) $display("FAIL t4_latency got %0d want 1", ed); else n_pass++;
        n_chk++; if (d !== x.mask) $display("FAIL t4_done got %b want %b", d, x.mask); else n_pass++;
        n_chk++; if (e !== 1'b1) $display("FAIL t4_err got %b want 1", e); else n_pass++;
        n_chk++; if (q !== x.q) $display("FAIL t4_q got %b want %b", q, x.q); else n_pass++;
        n_chk++; if ((ec + sc + rc) !== 0) $display("FAIL t4_pins got %0d active cycles want 0", ec + sc + rc); else n_pass++;
        @(negedge clk);
        n_chk++; if (bus.err !== 1'b0) $display("FAIL t4_err_pulse got %b want 0", bus.err); else n_pass++;
`ifdef SR_ERR_CNT_EN
        n_chk++; if (bus.err_cnt !== 8'h01) $display("FAIL t4_errcnt got %h want 01", bus.err_cnt); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid_op;
        logic [3:0] d; logic e, q; int ed, sc, rc, ec, w, seen; exp_t x;
        @(negedge clk);
        bus.req_s = 4'b0100;
        repeat (2) @(negedge clk);
        n_chk++; if (bus.lat_en !== 1'b1) $display("FAIL t5_in_pulse got %b want 1", bus.lat_en); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if ({bus.lat_en, bus.lat_s, bus.busy} !== 3'b000)
            $display("FAIL t5_async_clear got %b want 000", {bus.lat_en, bus.lat_s, bus.busy}); else n_pass++;
        n_chk++; if (bus.q_mirror !== 1'b0) $display("FAIL t5_q got %b want 0", bus.q_mirror); else n_pass++;
        bus.req_s = '0; mp = 0; mq = 1'b0; seen = 0;
        repeat (3) begin @(negedge clk); if (bus.done !== 4'b0000) seen++; end
        rst_n = 1'b1;
        repeat (3) begin @(negedge clk); if (bus.done !== 4'b0000) seen++; end
        n_chk++; if (seen !== 0) $display("FAIL t5_no_done got %0d pulses want 0", seen); else n_pass++;
        bus.req_s = 4'b1010;
        model_push(4'b1010, 4'b0000, w);
        model_push(4'b1010 & ~(4'b0001 << w), 4'b0000, w);
        for (int n = 0; n < 2; n++) begin
            wait_done(20, d, e, q, ed, sc, rc, ec);
            bus.req_s &= ~d; bus.req_r &= ~d;
            x = sb.pop_front();
            n_chk++; if (d !== x.mask) $display("FAIL t5_done[%0d] got %b want %b", n, d, x.mask); else n_pass++;
            n_chk++; if (q !== x.q) $display("FAIL t5_q[%0d] got %b want %b", n, q, x.q); else n_pass++;
            n_chk++; if (ec !== 2) $display("FAIL t5_en_cycles[%0d] got %0d want 2", n, ec); else n_pass++;
        end
    endtask

    task automatic test_drop_in_setup;
        logic [3:0] d; logic e, q; int ed, sc, rc, ec, w; exp_t x;
        @(negedge clk);
        bus.req_r = 4'b0001;
        model_push(bus.req_s, bus.req_r, w);
        @(negedge clk);
        n_chk++; if ({bus.lat_s, bus.lat_r, bus.lat_en} !== 3'b010)
            $display("FAIL t6_setup got %b want 010", {bus.lat_s, bus.lat_r, bus.lat_en}); else n_pass++;
        bus.req_r = 4'b0000;
        wait_done(20, d, e, q, ed, sc, rc, ec);
        x = sb.pop_front();
        n_chk++; if (ed + 1 !== 5) $display("FAIL t6_latency got %0d want 5", ed + 1); else n_pass++;
        n_chk++; if (d !== x.mask) $display("FAIL t6_done got %b want %b", d, x.mask); else n_pass++;
        n_chk++; if (q !== x.q) $display("FAIL t6_q got %b want %b", q, x.q); else n_pass++;
        n_chk++; if (e !== 1'b0) $display("FAIL t6_err got %b want 0", e); else n_pass++;
        n_chk++; if (both_cnt !== 0) $display("FAIL s_and_r got %0d cycles want 0", both_cnt); else n_pass++;
    endtask

`ifdef SR_ERR_CNT_EN
    task automatic test_err_saturate;
        logic [3:0] d; logic e, q; int ed, sc, rc, ec;
        for (int n = 0; n < 260; n++) begin
            @(negedge clk);
            bus.req_s = 4'b0100; bus.req_r = 4'b0100;
            wait_done(20, d, e, q, ed, sc, rc, ec);
            bus.req_s = '0; bus.req_r = '0;
        end
        @(negedge clk);
        n_chk++; if (bus.err_cnt !== 8'hFF) $display("FAIL errcnt_sat got %h want ff", bus.err_cnt); else n_pass++;
    endtask
`endif

    initial begin
        bus.req_s = '0;
        bus.req_r = '0;
        test_reset();
        test_single_set();
        test_two_requests();
        test_round_robin();
        test_illegal();
        test_reset_mid_op();
        test_drop_in_setup();
`ifdef SR_ERR_CNT_EN
        test_err_saturate();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
